// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the patch LED sequencer:
//   - colour codes as produced by the colour-sensor classifier
//   - 3-bit RGB pin patterns for one LED slot
//   - color_to_rgb encoder
//   - sequencer state enum
//   - ptr_width helper (slot pointer is at least one bit wide)
// -----------------------------------------------------------------------------
package led_pkg;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    localparam logic [2:0] RGB_OFF   = 3'b000;
    localparam logic [2:0] RGB_RED   = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HELD    = 2'd2,
        ST_BLINK   = 2'd3
    } state_t;

    // Map a classifier colour code onto the pin pattern of one RGB LED.
    function automatic logic [2:0] color_to_rgb(input logic [1:0] color);
        logic [2:0] rgb_s;
        case (color)
            COLOR_RED:   rgb_s = RGB_RED;
            COLOR_GREEN: rgb_s = RGB_GREEN;
            COLOR_BLUE:  rgb_s = RGB_BLUE;
            default:     rgb_s = RGB_OFF;
        endcase
        return rgb_s;
    endfunction

    // Width of a pointer addressing n slots; a single slot still gets one bit.
    function automatic int ptr_width(input int n);
        int w_s;
        if (n > 1) begin
            w_s = $clog2(n);
        end else begin
            w_s = 1;
        end
        return w_s;
    endfunction

endpackage

// File: rtl/patch_led_sequencer_if.sv
// -----------------------------------------------------------------------------
// patch_led_sequencer_if
// Groups the sequencer's sensor/navigation inputs and LED-side outputs.
//   color        : detected colour code (0 none, 1 red, 2 green, 3 blue)
//   lap_done     : single-cycle strobe, clears all slots
//   done         : level, LEDs blink green while high
//   patch_enable : registered "colour present and not in done mode"
//   rgb          : 3 bits per slot, slot k at [3k+2:3k]
//   slot_ptr     : next slot to fill
//   full         : all slots latched (hold-at-end mode only)
// Modports: master drives the inputs (environment), slave is the sequencer.
// -----------------------------------------------------------------------------
interface patch_led_sequencer_if
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 3
) ();

    localparam int PTR_W = ptr_width(NUM_LEDS);

    logic [1:0]            color;
    logic                  lap_done;
    logic                  done;
    logic                  patch_enable;
    logic [3*NUM_LEDS-1:0] rgb;
    logic [PTR_W-1:0]      slot_ptr;
    logic                  full;

    modport master (
        output color, lap_done, done,
        input  patch_enable, rgb, slot_ptr, full
    );

    modport slave (
        input  color, lap_done, done,
        output patch_enable, rgb, slot_ptr, full
    );

endinterface

// File: rtl/blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Free-running half-period timer for the done-mode blink.
//   clk_1MHz : system clock
//   reset    : synchronous, active-high
//   enable   : counts while high; low clears counter and phase
//   phase    : toggles every BLINK_CYCLES enabled cycles, starts low
// -----------------------------------------------------------------------------
module blink_timer #(
    parameter int BLINK_CYCLES = 1000000
) (
    input  logic clk_1MHz,
    input  logic reset,
    input  logic enable,
    output logic phase
);

    localparam int              CNT_W    = $clog2(BLINK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;

    // Half-period counter: wraps at BLINK_CYCLES-1 and flips the phase there.
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (!enable) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            phase_r <= phase_r;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/patch_led_sequencer.sv
// -----------------------------------------------------------------------------
// patch_led_sequencer
// Latches each stable detected patch colour into the next free RGB LED slot.
//   clk_1MHz : system clock
//   reset    : synchronous, active-high
//   bus      : patch_led_sequencer_if.slave (color/lap_done/done in,
//              patch_enable/rgb/slot_ptr/full out, all outputs registered)
// A colour must be seen on STABLE_CYCLES consecutive samples after the one
// that woke the FSM from IDLE before it is written. The slot is frozen until
// the colour disappears, then the pointer advances. done overrides everything
// except reset and shows a green blink on all slots.
// -----------------------------------------------------------------------------
module patch_led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS      = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_CYCLES  = 1000000,
    parameter int WRAP_MODE     = 0
) (
    input  logic                  clk_1MHz,
    input  logic                  reset,
    patch_led_sequencer_if.slave  bus
);

    localparam int               PTR_W       = ptr_width(NUM_LEDS);
    localparam int               CNT_W       = $clog2(STABLE_CYCLES + 1);
    localparam int               RGB_W       = 3 * NUM_LEDS;
    localparam logic [PTR_W-1:0] LAST_SLOT   = PTR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RGB_W-1:0] BLINK_ALL   = {NUM_LEDS{RGB_GREEN}};

    state_t           state_r,        state_nx_s;
    logic [CNT_W-1:0] cnt_r,          cnt_nx_s;
    logic [1:0]       cap_color_r,    cap_color_nx_s;
    logic [PTR_W-1:0] slot_ptr_r,     slot_ptr_nx_s;
    logic [RGB_W-1:0] rgb_r,          rgb_nx_s;
    logic             full_r,         full_nx_s;
    logic             patch_enable_r, patch_enable_nx_s;

    logic [1:0]       color_s;
    logic             lap_done_s;
    logic             done_s;
    logic             blink_phase_s;

    assign color_s    = bus.color;
    assign lap_done_s = bus.lap_done;
    assign done_s     = bus.done;

    blink_timer #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink_timer (
        .clk_1MHz (clk_1MHz),
        .reset    (reset),
        .enable   (done_s),
        .phase    (blink_phase_s)
    );

    // Next-state and next-output logic; done beats lap_done beats capture.
    always_comb begin
        state_nx_s        = state_r;
        cnt_nx_s          = cnt_r;
        cap_color_nx_s    = cap_color_r;
        slot_ptr_nx_s     = slot_ptr_r;
        rgb_nx_s          = rgb_r;
        full_nx_s         = full_r;
        patch_enable_nx_s = (color_s != COLOR_NONE) && !done_s;

        if (done_s) begin
            // Slots and pointer are kept during the blink; only rgb is overlaid.
            state_nx_s     = ST_BLINK;
            cnt_nx_s       = '0;
            cap_color_nx_s = COLOR_NONE;
            if (blink_phase_s) begin
                rgb_nx_s = BLINK_ALL;
            end else begin
                rgb_nx_s = '0;
            end
        end else if ((state_r == ST_BLINK) || lap_done_s) begin
            // Leaving done mode and a lap boundary both start a fresh row.
            state_nx_s     = ST_IDLE;
            cnt_nx_s       = '0;
            cap_color_nx_s = COLOR_NONE;
            slot_ptr_nx_s  = '0;
            rgb_nx_s       = '0;
            full_nx_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The waking sample itself does not count towards stability.
                    if ((color_s != COLOR_NONE) && !full_r) begin
                        state_nx_s     = ST_CAPTURE;
                        cnt_nx_s       = '0;
                        cap_color_nx_s = color_s;
                    end else begin
                        state_nx_s     = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (color_s == COLOR_NONE) begin
                        state_nx_s     = ST_IDLE;
                        cnt_nx_s       = '0;
                        cap_color_nx_s = COLOR_NONE;
                    end else if (color_s != cap_color_r) begin
                        cnt_nx_s       = '0;
                        cap_color_nx_s = color_s;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nx_s = ST_HELD;
                        for (int k = 0; k < NUM_LEDS; k++) begin
                            if (PTR_W'(k) == slot_ptr_r) begin
                                rgb_nx_s[3*k +: 3] = color_to_rgb(cap_color_r);
                            end else begin
                                rgb_nx_s[3*k +: 3] = rgb_r[3*k +: 3];
                            end
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (color_s == COLOR_NONE) begin
                        state_nx_s     = ST_IDLE;
                        cnt_nx_s       = '0;
                        cap_color_nx_s = COLOR_NONE;
                        if (slot_ptr_r < LAST_SLOT) begin
                            slot_ptr_nx_s = slot_ptr_r + PTR_W'(1);
                        end else if (WRAP_MODE == 0) begin
                            slot_ptr_nx_s = '0;
                            rgb_nx_s      = '0;
                        end else begin
                            // Row complete: hold everything until lap_done.
                            full_nx_s     = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_HELD;
                    end
                end
                default: begin
                    state_nx_s     = ST_IDLE;
                    cnt_nx_s       = '0;
                    cap_color_nx_s = COLOR_NONE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            cap_color_r    <= COLOR_NONE;
            slot_ptr_r     <= '0;
            rgb_r          <= '0;
            full_r         <= 1'b0;
            patch_enable_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            cnt_r          <= cnt_nx_s;
            cap_color_r    <= cap_color_nx_s;
            slot_ptr_r     <= slot_ptr_nx_s;
            rgb_r          <= rgb_nx_s;
            full_r         <= full_nx_s;
            patch_enable_r <= patch_enable_nx_s;
        end
    end

    assign bus.patch_enable = patch_enable_r;
    assign bus.rgb          = rgb_r;
    assign bus.slot_ptr     = slot_ptr_r;
    assign bus.full         = full_r;

endmodule
